// File: rtl/mips_run_ctrl_if.sv
// Debug/run-control bus between the top-level debug inputs and mips_run_ctrl.
// master: debug source plus core PC/Instr; slave: the run controller.
interface mips_run_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 Start;
  logic                 Stop;
  logic                 Step;
  logic                 Restart;
  logic                 BpEnable;
  logic [31:0]          BpAddr;
  logic [31:0]          PCAddr;
  logic [31:0]          Instr;
  logic                 CpuReset;
  logic                 CpuEnable;
  logic                 Halted;
  logic [1:0]           Cause;
  logic [CNT_WIDTH-1:0] CycleCount;

  modport master (
    output Start, Stop, Step, Restart,
    output BpEnable, BpAddr, PCAddr, Instr,
    input  CpuReset, CpuEnable, Halted,
    input  Cause, CycleCount
  );

  modport slave (
    input  Start, Stop, Step, Restart,
    input  BpEnable, BpAddr, PCAddr, Instr,
    output CpuReset, CpuEnable, Halted,
    output Cause, CycleCount
  );
endinterface

// File: rtl/mips_run_ctrl.sv
// Run/debug sequencer for the single-cycle MIPS core: reset stretch,
// free-run, single-step, PC breakpoint, BREAK stop and cycle watchdog.
// Ports: Clock, Reset (async, active-high), dbg (mips_run_ctrl_if.slave).
module mips_run_ctrl #(
  parameter int RESET_CYCLES = 4,
  parameter int CNT_WIDTH    = 32,
  parameter int MAX_CYCLES   = 0
) (
  input  logic           Clock,
  input  logic           Reset,
  mips_run_ctrl_if.slave dbg
);

  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(RESET_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(1);
  localparam logic [CNT_WIDTH-1:0] WD_LIM = CNT_WIDTH'(MAX_CYCLES);

  typedef enum logic [1:0] {
    RST_HOLD,
    HALT,
    RUN,
    STEP
  } state_e;

  state_e               state_q, state_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 first_q, first_d;
  logic [1:0]           cause_q, cause_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 cpu_reset_q, cpu_reset_d;
  logic                 halted_q, halted_d;

  logic brk_hit;
  logic bp_hit;
  logic wd_hit;
  logic cpu_en;
  logic cnt_clr;
  logic unused_instr;

  assign unused_instr = ^dbg.Instr[25:6];

  assign brk_hit = (dbg.Instr[31:26] == 6'h00) &&
                   (dbg.Instr[5:0] == 6'h0D);
  // first_q masks the compare so a resume at the bp address proceeds.
  assign bp_hit  = dbg.BpEnable && !first_q &&
                   (dbg.PCAddr == dbg.BpAddr);
  assign wd_hit  = (MAX_CYCLES != 0) && (cnt_q == WD_LIM);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    first_d = first_q;
    cause_d = cause_q;
    cnt_clr = 1'b0;
    cpu_en  = 1'b0;
    if (dbg.Restart) begin
      state_d = RST_HOLD;
      hold_d  = HOLD_INIT;
      cause_d = 2'd0;
      first_d = 1'b0;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        RST_HOLD: begin
          if (hold_q <= HOLD_LAST) begin
            state_d = HALT;
          end else begin
            hold_d = hold_q - HOLD_LAST;
          end
        end
        HALT: begin
          if (dbg.Stop) begin
            state_d = HALT;
          end else if (dbg.Step) begin
            state_d = STEP;
            cause_d = 2'd0;
          end else if (dbg.Start) begin
            state_d = RUN;
            cause_d = 2'd0;
            first_d = 1'b1;
          end
        end
        RUN: begin
          first_d = 1'b0;
          if (dbg.Stop) begin
            state_d = HALT;
            cause_d = 2'd0;
          end else if (brk_hit) begin
            state_d = HALT;
            cause_d = 2'd2;
          end else if (bp_hit) begin
            state_d = HALT;
            cause_d = 2'd1;
          end else if (wd_hit) begin
            state_d = HALT;
            cause_d = 2'd3;
          end else begin
            cpu_en = 1'b1;
          end
        end
        STEP: begin
          state_d = HALT;
          if (brk_hit) begin
            cause_d = 2'd2;
          end else if (wd_hit) begin
            cause_d = 2'd3;
          end else begin
            cpu_en = 1'b1;
          end
        end
        default: begin
          state_d = RST_HOLD;
          hold_d  = HOLD_INIT;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cpu_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign cpu_reset_d = (state_d == RST_HOLD);
  assign halted_d    = (state_d == RST_HOLD) ||
                       (state_d == HALT);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= RST_HOLD;
      hold_q      <= HOLD_INIT;
      first_q     <= 1'b0;
      cause_q     <= 2'd0;
      cnt_q       <= '0;
      cpu_reset_q <= 1'b1;
      halted_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      first_q     <= first_d;
      cause_q     <= cause_d;
      cnt_q       <= cnt_d;
      cpu_reset_q <= cpu_reset_d;
      halted_q    <= halted_d;
    end
  end

  assign dbg.CpuEnable  = cpu_en;
  assign dbg.CpuReset   = cpu_reset_q;
  assign dbg.Halted     = halted_q;
  assign dbg.Cause      = cause_q;
  assign dbg.CycleCount = cnt_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Testbench for mips_run_ctrl: random and directed run-control scenarios
// against a cycle-level reference model; second instance for the watchdog.
module tb_mips_run_ctrl;

  localparam int RC   = 4;
  localparam int W    = 8;
  localparam int SAT  = 255;
  localparam int WDW  = 32;
  localparam int WDMX = 5;

  localparam int MD_HOLD = 0;
  localparam int MD_HALT = 1;
  localparam int MD_RUN  = 2;
  localparam int MD_STEP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_run_ctrl_if #(.CNT_WIDTH(W))   m_if();
  mips_run_ctrl_if #(.CNT_WIDTH(WDW)) w_if();

  mips_run_ctrl #(
    .RESET_CYCLES(RC), .CNT_WIDTH(W), .MAX_CYCLES(0)
  ) u_dut (
    .Clock(clk), .Reset(rst), .dbg(m_if.slave)
  );

  mips_run_ctrl #(
    .RESET_CYCLES(RC), .CNT_WIDTH(WDW), .MAX_CYCLES(WDMX)
  ) u_wd (
    .Clock(clk), .Reset(rst), .dbg(w_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic        i_start, i_stop, i_step, i_restart, i_bpen;
  logic [31:0] i_bpaddr;
  logic [31:0] pc;
  logic [31:0] brk_pc;
  logic [31:0] r_instr;
  bit          rand_instr;

  int m_mode, m_rem, m_cause, m_cnt;
  bit m_first;
  bit exp_en;
  logic obs_en, obs_wen;

  function automatic logic [31:0] fetch();
    if (rand_instr) return r_instr;
    if (pc == brk_pc) return 32'h0000_000D;
    return 32'h0000_0000;
  endfunction

  task automatic idle_inputs();
    i_start = 0; i_stop = 0; i_step = 0;
    i_restart = 0;
  endtask

  task automatic model_reset();
    m_mode = MD_HOLD; m_rem = RC;
    m_cause = 0; m_cnt = 0; m_first = 0;
    pc = 0;
  endtask

  task automatic drive();
    logic [31:0] ins;
    ins = fetch();
    m_if.Start = i_start;   w_if.Start = i_start;
    m_if.Stop = i_stop;     w_if.Stop = i_stop;
    m_if.Step = i_step;     w_if.Step = i_step;
    m_if.Restart = i_restart;
    w_if.Restart = i_restart;
    m_if.BpEnable = i_bpen; w_if.BpEnable = i_bpen;
    m_if.BpAddr = i_bpaddr; w_if.BpAddr = i_bpaddr;
    m_if.PCAddr = pc;       w_if.PCAddr = pc;
    m_if.Instr = ins;       w_if.Instr = ins;
  endtask

  // One clock: apply inputs, evaluate the model, sample CpuEnable,
  // take the edge, advance model and the fake core PC.
  task automatic tick();
    logic [31:0] ins;
    bit brk, bp, to_hold;
    int n_mode, n_rem, n_cause, n_cnt;
    bit n_first;
    drive();
    #1;
    ins = fetch();
    brk = (ins[31:26] == 6'h00) && (ins[5:0] == 6'h0D);
    bp  = i_bpen && (pc == i_bpaddr);
    n_mode = m_mode; n_rem = m_rem;
    n_cause = m_cause; n_cnt = m_cnt;
    n_first = m_first;
    exp_en = 0;
    to_hold = i_restart;
    if (!to_hold) begin
      case (m_mode)
        MD_HOLD: begin
          if (m_rem <= 1) n_mode = MD_HALT;
          else n_rem = m_rem - 1;
        end
        MD_HALT: begin
          if (i_stop) n_mode = MD_HALT;
          else if (i_step) begin
            n_mode = MD_STEP; n_cause = 0;
          end else if (i_start) begin
            n_mode = MD_RUN; n_cause = 0;
            n_first = 1;
          end
        end
        MD_RUN: begin
          n_first = 0;
          n_mode = MD_HALT;
          if (i_stop) n_cause = 0;
          else if (brk) n_cause = 2;
          else if (bp && !m_first) n_cause = 1;
          else begin
            exp_en = 1; n_mode = MD_RUN;
          end
        end
        default: begin
          n_mode = MD_HALT;
          if (brk) n_cause = 2;
          else exp_en = 1;
        end
      endcase
    end else begin
      n_mode = MD_HOLD; n_rem = RC;
      n_cause = 0; n_cnt = 0; n_first = 0;
    end
    if (exp_en && n_cnt < SAT) n_cnt = n_cnt + 1;
    obs_en  = m_if.CpuEnable;
    obs_wen = w_if.CpuEnable;
    @(posedge clk);
    m_mode = n_mode; m_rem = n_rem;
    m_cause = n_cause; m_cnt = n_cnt;
    m_first = n_first;
    if (m_mode == MD_HOLD) pc = 0;
    else if (exp_en) pc = pc + 4;
    #1;
  endtask

  task automatic restart_core();
    idle_inputs();
    i_restart = 1; tick();
    i_restart = 0;
    repeat (RC) tick();
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    i_bpen = 0; i_bpaddr = 0;
    rst = 1;
    drive();
    #1;
    n_checks++;
    if (m_if.CpuReset !== 1'b1 || m_if.Halted !== 1'b1 ||
        m_if.CpuEnable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: rst=%b halt=%b en=%b want 1 1 0",
               m_if.CpuReset, m_if.Halted, m_if.CpuEnable);
    end
    n_checks++;
    if (m_if.Cause !== 2'd0 || m_if.CycleCount !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: cause=%0d cnt=%0d want 0 0",
               m_if.Cause, m_if.CycleCount);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    model_reset();
    n = 0;
    while (m_if.CpuReset === 1'b1 && n < 20) begin
      tick(); n++;
    end
    n_checks++;
    if (n != RC) begin
      n_fail++;
      $display("FAIL reset_stretch: edges=%0d want %0d", n, RC);
    end
    n_checks++;
    if (m_if.Halted !== 1'b1 || m_if.CycleCount !== '0) begin
      n_fail++;
      $display("FAIL reset_halt: halt=%b cnt=%0d want 1 0",
               m_if.Halted, m_if.CycleCount);
    end
  endtask

  task automatic test_free_run();
    int bad;
    restart_core();
    i_start = 1; tick(); i_start = 0;
    bad = 0;
    repeat (10) begin
      tick();
      if (obs_en !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL run_enable: low_cycles=%0d want 0", bad);
    end
    i_stop = 1; tick(); i_stop = 0;
    n_checks++;
    if (obs_en !== 1'b0) begin
      n_fail++;
      $display("FAIL run_stop_en: en=%b want 0", obs_en);
    end
    n_checks++;
    if (m_if.CycleCount !== 8'd10 || m_if.Halted !== 1'b1 ||
        m_if.Cause !== 2'd0) begin
      n_fail++;
      $display("FAIL run_stop: cnt=%0d halt=%b cause=%0d want 10 1 0",
               m_if.CycleCount, m_if.Halted, m_if.Cause);
    end
  endtask

  task automatic test_breakpoint();
    int k, bad;
    restart_core();
    i_bpen = 1; i_bpaddr = 32'h10;
    i_start = 1; tick(); i_start = 0;
    k = 0;
    tick();
    while (obs_en === 1'b1 && k < 20) begin
      k++; tick();
    end
    n_checks++;
    if (k != 4 || pc !== 32'h10) begin
      n_fail++;
      $display("FAIL bp_stop: ran=%0d pc=%0h want 4 10", k, pc);
    end
    n_checks++;
    if (m_if.Cause !== 2'd1 || m_if.CycleCount !== 8'd4 ||
        m_if.Halted !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_regs: cause=%0d cnt=%0d halt=%b want 1 4 1",
               m_if.Cause, m_if.CycleCount, m_if.Halted);
    end
    i_start = 1; tick(); i_start = 0;
    bad = 0;
    repeat (3) begin
      tick();
      if (obs_en !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0 || m_if.CycleCount !== 8'd7 ||
        m_if.Cause !== 2'd0) begin
      n_fail++;
      $display("FAIL bp_resume: low=%0d cnt=%0d cause=%0d want 0 7 0",
               bad, m_if.CycleCount, m_if.Cause);
    end
    i_stop = 1; tick(); i_stop = 0;
    i_bpen = 0;
  endtask

  task automatic test_step();
    int pulses, bad;
    restart_core();
    pulses = 0; bad = 0;
    repeat (3) begin
      i_step = 1; tick(); i_step = 0;
      if (obs_en !== 1'b0) bad++;
      tick();
      if (obs_en === 1'b1) pulses++;
      tick();
      if (obs_en !== 1'b0) bad++;
    end
    n_checks++;
    if (pulses != 3 || bad != 0 ||
        m_if.CycleCount !== 8'd3) begin
      n_fail++;
      $display("FAIL step3: pulses=%0d extra=%0d cnt=%0d want 3 0 3",
               pulses, bad, m_if.CycleCount);
    end
    i_step = 1; i_start = 1; tick();
    idle_inputs();
    tick();
    n_checks++;
    if (obs_en !== 1'b1 || m_if.Halted !== 1'b1 ||
        m_if.CycleCount !== 8'd4) begin
      n_fail++;
      $display("FAIL step_vs_start: en=%b halt=%b cnt=%0d want 1 1 4",
               obs_en, m_if.Halted, m_if.CycleCount);
    end
  endtask

  task automatic test_break_instr();
    int k;
    restart_core();
    brk_pc = 32'h8;
    i_start = 1; tick(); i_start = 0;
    k = 0;
    tick();
    while (obs_en === 1'b1 && k < 20) begin
      k++; tick();
    end
    n_checks++;
    if (k != 2 || m_if.Cause !== 2'd2 ||
        m_if.CycleCount !== 8'd2) begin
      n_fail++;
      $display("FAIL brk_stop: ran=%0d cause=%0d cnt=%0d want 2 2 2",
               k, m_if.Cause, m_if.CycleCount);
    end
    i_step = 1; tick(); i_step = 0;
    tick();
    n_checks++;
    if (obs_en !== 1'b0 || m_if.Cause !== 2'd2 ||
        m_if.CycleCount !== 8'd2) begin
      n_fail++;
      $display("FAIL brk_step: en=%b cause=%0d cnt=%0d want 0 2 2",
               obs_en, m_if.Cause, m_if.CycleCount);
    end
    brk_pc = 32'hFFFF_FFFF;
  endtask

  task automatic test_watchdog();
    int k, n;
    restart_core();
    i_start = 1; tick(); i_start = 0;
    k = 0;
    tick();
    while (obs_wen === 1'b1 && k < 20) begin
      k++; tick();
    end
    n_checks++;
    if (k != WDMX || w_if.CycleCount !== 32'd5 ||
        w_if.Cause !== 2'd3 || w_if.Halted !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_stop: ran=%0d cnt=%0d cause=%0d want 5 5 3",
               k, w_if.CycleCount, w_if.Cause);
    end
    i_stop = 1; tick(); i_stop = 0;
    i_step = 1; tick(); i_step = 0;
    tick();
    n_checks++;
    if (obs_wen !== 1'b0 || w_if.Cause !== 2'd3 ||
        w_if.CycleCount !== 32'd5) begin
      n_fail++;
      $display("FAIL wd_step: en=%b cause=%0d cnt=%0d want 0 3 5",
               obs_wen, w_if.Cause, w_if.CycleCount);
    end
    i_restart = 1; tick(); i_restart = 0;
    n_checks++;
    if (w_if.CpuReset !== 1'b1 || w_if.Cause !== 2'd0 ||
        w_if.CycleCount !== 32'd0) begin
      n_fail++;
      $display("FAIL wd_restart: rst=%b cause=%0d cnt=%0d want 1 0 0",
               w_if.CpuReset, w_if.Cause, w_if.CycleCount);
    end
    n = 0;
    while (w_if.CpuReset === 1'b1 && n < 20) begin
      tick(); n++;
    end
    n_checks++;
    if (n != RC) begin
      n_fail++;
      $display("FAIL restart_stretch: edges=%0d want %0d", n, RC);
    end
    i_start = 1; tick(); i_start = 0;
    repeat (2) tick();
    drive();
    #3;
    n_checks++;
    if (m_if.CpuEnable !== 1'b1 || w_if.CpuEnable !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_run: en=%b/%b want 1/1",
               m_if.CpuEnable, w_if.CpuEnable);
    end
    rst = 1;
    #1;
    n_checks++;
    if (m_if.CpuEnable !== 1'b0 || w_if.CpuEnable !== 1'b0 ||
        m_if.CpuReset !== 1'b1 || m_if.CycleCount !== '0) begin
      n_fail++;
      $display("FAIL async_reset: en=%b/%b rst=%b cnt=%0d want 0/0 1 0",
               m_if.CpuEnable, w_if.CpuEnable,
               m_if.CpuReset, m_if.CycleCount);
    end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    repeat (RC) tick();
  endtask

  task automatic test_saturate();
    restart_core();
    i_start = 1; tick(); i_start = 0;
    repeat (SAT + 5) tick();
    n_checks++;
    if (m_if.CycleCount !== 8'hFF || obs_en !== 1'b1) begin
      n_fail++;
      $display("FAIL saturate: cnt=%0d en=%b want 255 1",
               m_if.CycleCount, obs_en);
    end
    i_stop = 1; tick(); i_stop = 0;
  endtask

  task automatic test_random();
    int e_en, e_rs, e_hl, e_ca, e_ct;
    restart_core();
    rand_instr = 1;
    e_en = 0; e_rs = 0; e_hl = 0; e_ca = 0; e_ct = 0;
    repeat (500) begin
      i_restart = ($urandom_range(0, 59) == 0);
      i_stop    = ($urandom_range(0, 19) == 0);
      i_step    = ($urandom_range(0, 4) == 0);
      i_start   = ($urandom_range(0, 4) == 0);
      i_bpen    = ($urandom_range(0, 1) == 1);
      i_bpaddr  = 32'($urandom_range(0, 15)) << 2;
      r_instr   = $urandom;
      if ($urandom_range(0, 5) == 0)
        r_instr = {6'h00, r_instr[25:6], 6'h0D};
      tick();
      if (obs_en !== exp_en) e_en++;
      if (m_if.CpuReset !== (m_mode == MD_HOLD)) e_rs++;
      if (m_if.Halted !== (m_mode == MD_HOLD ||
                           m_mode == MD_HALT)) e_hl++;
      if (m_if.Cause !== 2'(m_cause)) e_ca++;
      if (m_if.CycleCount !== W'(m_cnt)) e_ct++;
    end
    rand_instr = 0;
    idle_inputs();
    i_bpen = 0;
    n_checks++;
    if (e_en != 0) begin
      n_fail++;
      $display("FAIL rnd_enable: bad_cycles=%0d want 0", e_en);
    end
    n_checks++;
    if (e_rs != 0 || e_hl != 0) begin
      n_fail++;
      $display("FAIL rnd_state: rst_bad=%0d halt_bad=%0d want 0 0",
               e_rs, e_hl);
    end
    n_checks++;
    if (e_ca != 0) begin
      n_fail++;
      $display("FAIL rnd_cause: bad_cycles=%0d want 0", e_ca);
    end
    n_checks++;
    if (e_ct != 0) begin
      n_fail++;
      $display("FAIL rnd_count: bad_cycles=%0d want 0", e_ct);
    end
  endtask

  initial begin
    idle_inputs();
    i_bpen = 0; i_bpaddr = 0;
    brk_pc = 32'hFFFF_FFFF;
    rand_instr = 0; r_instr = 0;
    model_reset();
    drive();
    @(posedge clk); #1;
    test_reset();
    test_free_run();
    test_breakpoint();
    test_step();
    test_break_instr();
    test_watchdog();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
